ptw_req_arbiter: RTL and testbench

- Sits directly downstream of two two-level TLB instances (instruction side and data side) and upstream of the shared page-table walker.
- Arbitrates their PTW miss requests round-robin and forwards one walk at a time.
- Routes the walker's PTE response back to the owning TLB.
- Drops responses for walks that are killed by a PTW invalidate (sfence).

---
 rtl/ptw_req_arbiter.sv | 125 ++++++++++++
 tb/tb_ptw_req_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_req_arbiter.sv
// rtl/ptw_req_arbiter.sv - round-robin arbiter between I-TLB and D-TLB page-table-walk requests
module ptw_req_arbiter #(
    parameter int REQ_W = 33,
    parameter int PPN_W = 38
) (
    input  logic             clock,
    input  logic             reset,
    output logic             io_c0_req_ready,
    input  logic             io_c0_req_valid,
    input  logic [REQ_W-1:0] io_c0_req_bits,
    output logic             io_c1_req_ready,
    input  logic             io_c1_req_valid,
    input  logic [REQ_W-1:0] io_c1_req_bits,
    output logic             io_c0_resp_valid,
    output logic             io_c1_resp_valid,
    output logic [PPN_W-1:0] io_resp_ppn,
    output logic [7:0]       io_resp_flags,
    input  logic             io_ptw_req_ready,
    output logic             io_ptw_req_valid,
    output logic [REQ_W-1:0] io_ptw_req_bits,
    input  logic             io_ptw_resp_valid,
    input  logic [PPN_W-1:0] io_ptw_resp_ppn,
    input  logic [7:0]       io_ptw_resp_flags,
    input  logic             io_ptw_invalidate,
    output logic             io_busy,
    output logic             io_owner
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t           r_state;
    // Client that wins the next tie: the opposite of the last served client.
    // Stored pre-inverted so reset (0) prefers client 0.
    logic             r_pref;
    logic             r_owner;
    logic             r_kill;
    logic [REQ_W-1:0] r_req_bits;
    logic             r_c0_resp_valid;
    logic             r_c1_resp_valid;
    logic [PPN_W-1:0] r_resp_ppn;
    logic [7:0]       r_resp_flags;

    logic w_idle;
    logic w_grant0;
    logic w_grant1;
    logic w_accept;

    // Grant decision: sole requester wins, ties go to the preferred client
    always_comb begin
        w_idle          = (r_state == S_IDLE);
        w_grant0        = io_c0_req_valid & (~io_c1_req_valid | ~r_pref);
        w_grant1        = io_c1_req_valid & (~io_c0_req_valid |  r_pref);
        io_c0_req_ready = w_idle & w_grant0 & ~io_ptw_invalidate;
        io_c1_req_ready = w_idle & w_grant1 & ~io_ptw_invalidate;
        w_accept        = io_c0_req_ready | io_c1_req_ready;
    end

    // Walk sequencing: accept, present to walker, await response, route it back
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_pref          <= 1'b0;
            r_owner         <= 1'b0;
            r_kill          <= 1'b0;
            r_req_bits      <= '0;
            r_c0_resp_valid <= 1'b0;
            r_c1_resp_valid <= 1'b0;
            r_resp_ppn      <= '0;
            r_resp_flags    <= '0;
        end else begin
            r_c0_resp_valid <= 1'b0;
            r_c1_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_REQ;
                        r_owner    <= io_c1_req_ready;
                        r_req_bits <= io_c1_req_ready ? io_c1_req_bits : io_c0_req_bits;
                    end
                end
                S_REQ: begin
                    // A flush abandons the request before the walker takes it
                    if (io_ptw_invalidate) begin
                        r_state <= S_IDLE;
                        r_owner <= 1'b0;
                    end else if (io_ptw_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (io_ptw_resp_valid) begin
                        r_resp_ppn      <= io_ptw_resp_ppn;
                        r_resp_flags    <= io_ptw_resp_flags;
                        r_c0_resp_valid <= ~r_kill & ~io_ptw_invalidate & ~r_owner;
                        r_c1_resp_valid <= ~r_kill & ~io_ptw_invalidate &  r_owner;
                        r_pref          <= ~r_owner;
                        r_kill          <= 1'b0;
                        r_owner         <= 1'b0;
                        r_state         <= S_IDLE;
                    end else if (io_ptw_invalidate) begin
                        // Walk already in flight: let it finish but drop its result
                        r_kill <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_ptw_req_valid = (r_state == S_REQ);
    assign io_ptw_req_bits  = r_req_bits;
    assign io_busy          = ~w_idle;
    assign io_owner         = r_owner;
    assign io_c0_resp_valid = r_c0_resp_valid;
    assign io_c1_resp_valid = r_c1_resp_valid;
    assign io_resp_ppn      = r_resp_ppn;
    assign io_resp_flags    = r_resp_flags;

endmodule

// File: tb/tb_ptw_req_arbiter.sv
// tb/tb_ptw_req_arbiter.sv - self-checking bench for ptw_req_arbiter
module tb_ptw_req_arbiter;

    localparam int REQ_W = 33;
    localparam int PPN_W = 38;

    logic             clock = 1'b0;
    logic             reset;
    logic             c0_req_ready, c1_req_ready;
    logic             c0_req_valid, c1_req_valid;
    logic [REQ_W-1:0] c0_req_bits, c1_req_bits;
    logic             c0_resp_valid, c1_resp_valid;
    logic [PPN_W-1:0] resp_ppn;
    logic [7:0]       resp_flags;
    logic             ptw_req_ready, ptw_req_valid;
    logic [REQ_W-1:0] ptw_req_bits;
    logic             ptw_resp_valid;
    logic [PPN_W-1:0] ptw_resp_ppn;
    logic [7:0]       ptw_resp_flags;
    logic             ptw_invalidate;
    logic             busy, owner;

    always #5 clock = ~clock;

    ptw_req_arbiter #(.REQ_W(REQ_W), .PPN_W(PPN_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .io_c0_req_ready   (c0_req_ready),
        .io_c0_req_valid   (c0_req_valid),
        .io_c0_req_bits    (c0_req_bits),
        .io_c1_req_ready   (c1_req_ready),
        .io_c1_req_valid   (c1_req_valid),
        .io_c1_req_bits    (c1_req_bits),
        .io_c0_resp_valid  (c0_resp_valid),
        .io_c1_resp_valid  (c1_resp_valid),
        .io_resp_ppn       (resp_ppn),
        .io_resp_flags     (resp_flags),
        .io_ptw_req_ready  (ptw_req_ready),
        .io_ptw_req_valid  (ptw_req_valid),
        .io_ptw_req_bits   (ptw_req_bits),
        .io_ptw_resp_valid (ptw_resp_valid),
        .io_ptw_resp_ppn   (ptw_resp_ppn),
        .io_ptw_resp_flags (ptw_resp_flags),
        .io_ptw_invalidate (ptw_invalidate),
        .io_busy           (busy),
        .io_owner          (owner)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one walk slot, a preference for whoever was not served last
    bit               m_known = 0;
    int               m_phase = 0;     // 0 idle, 1 presenting to walker, 2 walker busy
    int               m_owner = 0;
    int               m_pref  = 0;
    bit               m_kill  = 0;
    logic [REQ_W-1:0] m_bits  = '0;
    bit               m_p0 = 0, m_p1 = 0;
    logic [PPN_W-1:0] m_ppn   = '0;
    logic [7:0]       m_flags = '0;
    logic             s_r0, s_r1;

    task automatic step();
        int g;
        #1;
        g = -1;
        if (m_phase == 0 && !ptw_invalidate) begin
            if (c0_req_valid && c1_req_valid) g = m_pref;
            else if (c0_req_valid)            g = 0;
            else if (c1_req_valid)            g = 1;
        end
        s_r0 = c0_req_ready;
        s_r1 = c1_req_ready;
        if (m_known) begin
            chk("model_c0_req_ready", s_r0, g == 0);
            chk("model_c1_req_ready", s_r1, g == 1);
        end
        @(posedge clock);
        m_p0 = 0;
        m_p1 = 0;
        if (reset) begin
            m_known = 1; m_phase = 0; m_owner = 0; m_pref = 0; m_kill = 0;
            m_ppn = '0; m_flags = '0;
        end else if (m_phase == 0) begin
            if (g >= 0) begin
                m_phase = 1;
                m_owner = g;
                m_bits  = (g == 1) ? c1_req_bits : c0_req_bits;
            end
        end else if (m_phase == 1) begin
            if (ptw_invalidate)     m_phase = 0;
            else if (ptw_req_ready) m_phase = 2;
        end else begin
            if (ptw_resp_valid) begin
                m_ppn   = ptw_resp_ppn;
                m_flags = ptw_resp_flags;
                if (!m_kill && !ptw_invalidate) begin
                    if (m_owner == 0) m_p0 = 1;
                    else              m_p1 = 1;
                end
                m_pref  = 1 - m_owner;
                m_kill  = 0;
                m_phase = 0;
            end else if (ptw_invalidate) begin
                m_kill = 1;
            end
        end
        #1;
        if (m_known) begin
            chk("model_ptw_req_valid", ptw_req_valid, m_phase == 1);
            chk("model_busy", busy, m_phase != 0);
            chk("model_owner", owner, (m_phase != 0) ? m_owner[0] : 1'b0);
            chk("model_c0_resp_valid", c0_resp_valid, m_p0);
            chk("model_c1_resp_valid", c1_resp_valid, m_p1);
            chk("model_resp_ppn", resp_ppn, m_ppn);
            chk("model_resp_flags", resp_flags, m_flags);
            if (m_phase == 1) chk("model_ptw_req_bits", ptw_req_bits, m_bits);
        end
    endtask

    task automatic drive(input bit rst, input bit v0, input bit v1, input bit inv,
                         input bit pr, input bit rv, input logic [PPN_W-1:0] ppn,
                         input logic [7:0] flags);
        reset          = rst;
        c0_req_valid   = v0;
        c1_req_valid   = v1;
        ptw_invalidate = inv;
        ptw_req_ready  = pr;
        ptw_resp_valid = rv;
        ptw_resp_ppn   = ppn;
        ptw_resp_flags = flags;
    endtask

    typedef struct {
        bit               rst, v0, v1, inv, pr, rv;
        logic [PPN_W-1:0] ppn;
        logic [7:0]       flags;
        bit               r0, r1, pv, bsy, own, p0, p1;
        logic [PPN_W-1:0] eppn;
        logic [7:0]       eflags;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit rst, bit v0, bit v1, bit inv, bit pr, bit rv,
                                logic [PPN_W-1:0] ppn, logic [7:0] flags,
                                bit r0, bit r1, bit pv, bit bsy, bit own, bit p0, bit p1,
                                logic [PPN_W-1:0] eppn, logic [7:0] eflags);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.v1 = v1; v.inv = inv; v.pr = pr; v.rv = rv;
        v.ppn = ppn; v.flags = flags;
        v.r0 = r0; v.r1 = r1; v.pv = pv; v.bsy = bsy; v.own = own; v.p0 = p0; v.p1 = p1;
        v.eppn = eppn; v.eflags = eflags;
        tbl.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] rnd;
        logic [32:0] b0, b1;
        b0 = 33'h1_0000_1234;
        b1 = 33'h0_0ABC_DEF0;
        c0_req_bits = b0;
        c1_req_bits = b1;
        drive(1, 0, 0, 0, 0, 0, '0, '0);
        step();
        step();
        chk("reset_busy", busy, 1'b0);
        chk("reset_owner", owner, 1'b0);
        chk("reset_ptw_req_valid", ptw_req_valid, 1'b0);
        chk("reset_resp_ppn", resp_ppn, '0);
        chk("reset_resp_flags", resp_flags, '0);
        chk("reset_resp_valid", {c0_resp_valid, c1_resp_valid}, 2'b00);

        //   rst v0 v1 inv pr rv ppn      flags  r0 r1 pv bsy own p0 p1 eppn     eflags
        add(0, 1, 0, 0, 0, 0, 0,        0,     1, 0, 1, 1, 0, 0, 0, 0,        0);
        add(0, 0, 0, 0, 1, 0, 0,        0,     0, 0, 0, 1, 0, 0, 0, 0,        0);
        add(0, 0, 0, 0, 0, 1, 'h12345,  'hCF,  0, 0, 0, 0, 0, 1, 0, 'h12345,  'hCF);
        add(0, 0, 0, 0, 0, 0, 0,        0,     0, 0, 0, 0, 0, 0, 0, 'h12345,  'hCF);
        add(1, 0, 0, 0, 0, 0, 0,        0,     0, 0, 0, 0, 0, 0, 0, 0,        0);
        add(0, 1, 1, 0, 0, 0, 0,        0,     1, 0, 1, 1, 0, 0, 0, 0,        0);
        add(0, 1, 1, 0, 1, 0, 0,        0,     0, 0, 0, 1, 0, 0, 0, 0,        0);
        add(0, 1, 1, 0, 0, 1, 'h111,    'h01,  0, 0, 0, 0, 0, 1, 0, 'h111,    'h01);
        add(0, 1, 1, 0, 0, 0, 0,        0,     0, 1, 1, 1, 1, 0, 0, 'h111,    'h01);
        add(0, 1, 1, 0, 1, 0, 0,        0,     0, 0, 0, 1, 1, 0, 0, 'h111,    'h01);
        add(0, 1, 1, 0, 0, 1, 'h222,    'h03,  0, 0, 0, 0, 0, 0, 1, 'h222,    'h03);
        add(0, 1, 1, 0, 0, 0, 0,        0,     1, 0, 1, 1, 0, 0, 0, 'h222,    'h03);
        add(0, 1, 1, 0, 1, 0, 0,        0,     0, 0, 0, 1, 0, 0, 0, 'h222,    'h03);
        add(0, 1, 1, 0, 0, 1, 'h333,    'h07,  0, 0, 0, 0, 0, 1, 0, 'h333,    'h07);
        add(0, 1, 1, 0, 0, 0, 0,        0,     0, 1, 1, 1, 1, 0, 0, 'h333,    'h07);
        add(0, 1, 1, 0, 1, 0, 0,        0,     0, 0, 0, 1, 1, 0, 0, 'h333,    'h07);
        add(0, 1, 1, 0, 0, 1, 'h444,    'h0F,  0, 0, 0, 0, 0, 0, 1, 'h444,    'h0F);
        add(0, 1, 0, 1, 0, 0, 0,        0,     0, 0, 0, 0, 0, 0, 0, 'h444,    'h0F);
        add(0, 1, 0, 0, 0, 0, 0,        0,     1, 0, 1, 1, 0, 0, 0, 'h444,    'h0F);
        add(0, 0, 0, 1, 1, 0, 0,        0,     0, 0, 0, 0, 0, 0, 0, 'h444,    'h0F);
        add(0, 0, 0, 0, 0, 1, 'h555,    'hFF,  0, 0, 0, 0, 0, 0, 0, 'h444,    'h0F);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].v0, tbl[i].v1, tbl[i].inv, tbl[i].pr, tbl[i].rv,
                  tbl[i].ppn, tbl[i].flags);
            step();
            chk($sformatf("vec%0d_c0_req_ready", i), s_r0, tbl[i].r0);
            chk($sformatf("vec%0d_c1_req_ready", i), s_r1, tbl[i].r1);
            chk($sformatf("vec%0d_ptw_req_valid", i), ptw_req_valid, tbl[i].pv);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("vec%0d_owner", i), owner, tbl[i].own);
            chk($sformatf("vec%0d_c0_resp_valid", i), c0_resp_valid, tbl[i].p0);
            chk($sformatf("vec%0d_c1_resp_valid", i), c1_resp_valid, tbl[i].p1);
            chk($sformatf("vec%0d_resp_ppn", i), resp_ppn, tbl[i].eppn);
            chk($sformatf("vec%0d_resp_flags", i), resp_flags, tbl[i].eflags);
            if (tbl[i].pv) chk($sformatf("vec%0d_ptw_req_bits", i), ptw_req_bits,
                                tbl[i].own ? b1 : b0);
        end

        // Walker stall: request must stay up and stable, clients locked out
        drive(0, 0, 1, 0, 0, 0, '0, '0);
        step();
        chk("stall_accept_c1", s_r1, 1'b1);
        chk("stall_owner", owner, 1'b1);
        drive(0, 1, 1, 0, 0, 0, '0, '0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_ptw_req_valid", ptw_req_valid, 1'b1);
            chk("stall_ptw_req_bits", ptw_req_bits, b1);
            chk("stall_client_ready", {s_r0, s_r1}, 2'b00);
        end
        drive(0, 0, 0, 0, 1, 0, '0, '0);
        step();
        chk("stall_handshake_valid", ptw_req_valid, 1'b0);
        chk("stall_handshake_busy", busy, 1'b1);
        drive(0, 0, 0, 0, 0, 1, 'h666, 'h5A);
        step();
        chk("stall_resp_c1", {c0_resp_valid, c1_resp_valid}, 2'b01);
        chk("stall_resp_ppn", resp_ppn, 'h666);

        // Invalidate while walking, response three cycles later is dropped
        drive(0, 0, 1, 0, 0, 0, '0, '0);
        step();
        chk("kill_accept_c1", s_r1, 1'b1);
        chk("kill_pulse_gone", c1_resp_valid, 1'b0);
        drive(0, 0, 0, 0, 1, 0, '0, '0);
        step();
        drive(0, 0, 0, 1, 0, 0, '0, '0);
        step();
        chk("kill_busy", busy, 1'b1);
        drive(0, 0, 0, 0, 0, 0, '0, '0);
        step();
        step();
        drive(0, 0, 0, 0, 0, 1, 'h777, 'h11);
        step();
        chk("kill_no_pulse", {c0_resp_valid, c1_resp_valid}, 2'b00);
        chk("kill_idle", busy, 1'b0);
        drive(0, 0, 1, 0, 0, 0, '0, '0);
        step();
        chk("after_kill_accept_c1", s_r1, 1'b1);
        drive(0, 0, 0, 0, 1, 0, '0, '0);
        step();
        drive(0, 0, 0, 0, 0, 1, 'h888, 'h22);
        step();
        chk("after_kill_resp_c1", {c0_resp_valid, c1_resp_valid}, 2'b01);
        chk("after_kill_ppn", resp_ppn, 'h888);

        // Reset mid-walk, stale walker response must be ignored
        drive(0, 1, 0, 0, 0, 0, '0, '0);
        step();
        chk("rstwait_accept_c0", s_r0, 1'b1);
        drive(0, 0, 0, 0, 1, 0, '0, '0);
        step();
        drive(1, 0, 0, 0, 0, 0, '0, '0);
        step();
        chk("rstwait_busy", busy, 1'b0);
        drive(0, 0, 0, 0, 0, 1, 'h999, 'h33);
        step();
        chk("rstwait_no_pulse", {c0_resp_valid, c1_resp_valid}, 2'b00);
        chk("rstwait_busy_after", busy, 1'b0);
        chk("rstwait_ppn", resp_ppn, '0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            rnd = {$urandom(), $urandom()};
            c0_req_bits = rnd[32:0];
            rnd = {$urandom(), $urandom()};
            c1_req_bits = rnd[32:0];
            rnd = {$urandom(), $urandom()};
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                  rnd[37:0], rnd[45:38]);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
